// File: rtl/wb_data_mux_pipe.sv
// rtl/wb_data_mux_pipe.sv - registered write-back source selector with a 2-entry skid queue
module wb_data_mux_pipe #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [DATA_W-1:0]           out_data,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_we,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err,
  input  logic                        err_clr,
  output logic [1:0]                  count
);

  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_addr;
  logic              skid_we;
  logic              skid_valid;

  logic [DATA_W-1:0] new_data;
  logic              new_we;
  logic              sel_ok;
  logic              accept;
  logic              pop;

  // The skid slot is only ever occupied behind a valid head, so it alone marks "full".
  assign in_ready = ~skid_valid;
  assign count    = {skid_valid, out_valid & ~skid_valid};
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;

  always_comb begin
    new_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        new_data = src_data[k*DATA_W +: DATA_W];
        sel_ok   = 1'b1;
      end
    end
    new_we = sel_ok & (in_addr != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_addr   <= '0;
      out_we     <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_addr  <= '0;
      skid_we    <= 1'b0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      // A new bad select outranks a simultaneous clear.
      if (accept && !sel_ok) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end

      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (pop) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_addr   <= skid_addr;
          out_we     <= skid_we;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_data <= new_data;
          out_addr <= in_addr;
          out_we   <= new_we;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid) begin
          out_data  <= new_data;
          out_addr  <= in_addr;
          out_we    <= new_we;
          out_valid <= 1'b1;
        end else begin
          skid_data  <= new_data;
          skid_addr  <= in_addr;
          skid_we    <= new_we;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_data_mux_pipe.sv
// tb/tb_wb_data_mux_pipe.sv - table-driven and scoreboard bench for wb_data_mux_pipe
module tb_wb_data_mux_pipe;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;
  localparam int ADDR_W  = 5;

  logic                      clk;
  logic                      reset_n;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          in_sel;
  logic [ADDR_W-1:0]         in_addr;
  logic                      in_valid;
  logic                      in_ready;
  logic                      flush;
  logic [DATA_W-1:0]         out_data;
  logic [ADDR_W-1:0]         out_addr;
  logic                      out_we;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
  logic                      err_clr;
  logic [1:0]                count;

  wb_data_mux_pipe #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .in_sel(in_sel),
    .in_addr(in_addr), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_addr(out_addr), .out_we(out_we),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .err_clr(err_clr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [4:0] addr;
    logic       ordy;
    logic       fl;
    logic       clr;
    logic [1:0] exp_count;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
  } ent_t;

  logic [31:0] srcs [NUM_SRC];
  vec_t        vecs [$];
  ent_t        sb   [$];
  ent_t        last;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ent_t model(input logic [2:0] sel, input logic [4:0] addr);
    ent_t e;
    e.addr = addr;
    e.data = (sel < NUM_SRC) ? srcs[sel] : 32'h0;
    e.we   = (sel < NUM_SRC) && (addr != 5'd0);
    return e;
  endfunction

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [4:0] addr,
                              input logic ordy, input logic fl, input logic clr,
                              input logic [1:0] ec, input logic ee);
    vec_t t;
    t.v = v; t.sel = sel; t.addr = addr; t.ordy = ordy; t.fl = fl; t.clr = clr;
    t.exp_count = ec; t.exp_err = ee;
    return t;
  endfunction

  // Compare live outputs against the queue model, then advance the model across the edge.
  task automatic apply(input vec_t t, input int idx);
    logic acc, pp;
    ent_t e;
    @(negedge clk);
    in_valid = t.v; in_sel = t.sel; in_addr = t.addr;
    out_ready = t.ordy; flush = t.fl; err_clr = t.clr;
    #1;
    chk($sformatf("count[%0d]", idx), 32'(count), 32'(sb.size()));
    chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'(sb.size() != 2));
    chk($sformatf("out_valid[%0d]", idx), 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk($sformatf("head_data[%0d]", idx), out_data, sb[0].data);
      chk($sformatf("head_addr[%0d]", idx), 32'(out_addr), 32'(sb[0].addr));
      chk($sformatf("head_we[%0d]", idx), 32'(out_we), 32'(sb[0].we));
    end else begin
      chk($sformatf("hold_data[%0d]", idx), out_data, last.data);
      chk($sformatf("hold_addr[%0d]", idx), 32'(out_addr), 32'(last.addr));
      chk($sformatf("hold_we[%0d]", idx), 32'(out_we), 32'(last.we));
    end
    acc = t.v && (sb.size() != 2) && !t.fl;
    pp  = (sb.size() != 0) && t.ordy && !t.fl;
    if (t.fl) begin
      if (sb.size() != 0) last = sb[0];
      sb.delete();
    end
    if (pp) begin
      last = sb.pop_front();
    end
    if (acc) begin
      e = model(t.sel, t.addr);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk($sformatf("count_after[%0d]", idx), 32'(count), 32'(t.exp_count));
    chk($sformatf("sel_err_after[%0d]", idx), 32'(sel_err), 32'(t.exp_err));
  endtask

  initial begin
    checks = 0; errors = 0;
    srcs[0] = 32'd227;       srcs[1] = 32'hDEAD_BEEF; srcs[2] = 32'h0000_1234;
    srcs[3] = 32'h3333_0003; srcs[4] = 32'hAAAA_0000; srcs[5] = 32'h0000_5555;
    for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = srcs[k];
    last = '{data: 32'h0, addr: 5'd0, we: 1'b0};

    //            v  sel addr ordy fl clr cnt err
    vecs.push_back(mk(1, 2,  9, 1, 0, 0, 1, 0));  // single write
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  1, 0, 0, 0, 1, 0));  // backpressure fill
    vecs.push_back(mk(1, 4,  2, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 5,  3, 0, 0, 0, 2, 0));  // held: full
    vecs.push_back(mk(1, 5,  3, 1, 0, 0, 1, 0));  // pop from full, offer still held
    vecs.push_back(mk(1, 5,  3, 1, 0, 0, 1, 0));  // accept+pop at count 1
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3,  4, 1, 0, 0, 1, 0));  // streaming
    vecs.push_back(mk(1, 1,  5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2,  6, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  7, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  0, 1, 0, 0, 1, 0));  // register 0
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7,  8, 1, 0, 0, 1, 1));  // out-of-range select
    vecs.push_back(mk(1, 7,  8, 1, 0, 1, 1, 1));  // set beats clear
    vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0, 0));  // clear alone
    vecs.push_back(mk(1, 6, 10, 1, 0, 0, 1, 1));  // first illegal index
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0));  // head held while stalled
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 11, 0, 0, 0, 1, 0));  // flush at full
    vecs.push_back(mk(1, 3, 12, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 4, 13, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7,  1, 0, 1, 0, 0, 0));  // flush drops bad offer, no error
    vecs.push_back(mk(1, 5, 14, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 15, 0, 0, 0, 2, 0));

    in_valid = 0; in_sel = 0; in_addr = 0; out_ready = 0; flush = 0; err_clr = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset between edges with a full queue.
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #2 reset_n = 0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    last = '{data: 32'h0, addr: 5'd0, we: 1'b0};
    @(negedge clk);
    reset_n = 1;
    apply(mk(1, 4, 3, 1, 0, 0, 1, 0), 100);
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
